// File: rtl/lrhls_mul_pipe.sv
// lrhls_mul_pipe: multi-lane unsigned x signed multiplier with scaling shift, rounding,
// valid/ready pipeline and sticky overflow. Define LRHLS_MUL_SAT_EN to saturate instead of wrap.
module lrhls_mul_pipe #(
  parameter int A_WIDTH   = 13,
  parameter int B_WIDTH   = 18,
  parameter int P_WIDTH   = 18,
  parameter int SHIFT     = 0,
  parameter int NUM_STAGE = 3,
  parameter int LANES     = 1
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*A_WIDTH-1:0]   din0,
  input  logic [LANES*B_WIDTH-1:0]   din1,
  input  logic                       rnd_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*P_WIDTH-1:0]   dout,
  output logic [LANES-1:0]           ovf,
  input  logic                       ovf_clr
);
  localparam int FW = A_WIDTH + B_WIDTH + 1;
  localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [FW-1:0] HALF = (SHIFT > 0) ? ({{(FW-1){1'b0}}, 1'b1} << HS) : '0;

  logic [LANES*P_WIDTH-1:0] lane_res;
  logic [LANES-1:0]         lane_ovf;

  // The full product always fits FW bits, and so does product + HALF, so no guard bits are needed.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [FW-1:0] a_ext;
    logic signed [FW-1:0] b_ext;
    logic signed [FW-1:0] prod;
    logic signed [FW-1:0] rnd_add;
    logic signed [FW-1:0] q;
    logic [FW-P_WIDTH:0]  top;
    logic                 out_rng;

    assign a_ext   = $signed({{(FW-A_WIDTH){1'b0}}, din0[l*A_WIDTH +: A_WIDTH]});
    assign b_ext   = $signed({{(FW-B_WIDTH){din1[l*B_WIDTH+B_WIDTH-1]}}, din1[l*B_WIDTH +: B_WIDTH]});
    assign prod    = a_ext * b_ext;
    assign rnd_add = rnd_mode ? $signed(HALF) : $signed({FW{1'b0}});
    assign q       = (prod + rnd_add) >>> SHIFT;
    assign top     = q[FW-1:P_WIDTH-1];
    assign out_rng = !((&top) || !(|top));
    assign lane_ovf[l] = out_rng;
`ifdef LRHLS_MUL_SAT_EN
    assign lane_res[l*P_WIDTH +: P_WIDTH] = !out_rng ? q[P_WIDTH-1:0] :
                                            q[FW-1]  ? {1'b1, {(P_WIDTH-1){1'b0}}} :
                                                       {1'b0, {(P_WIDTH-1){1'b1}}};
`else
    assign lane_res[l*P_WIDTH +: P_WIDTH] = q[P_WIDTH-1:0];
`endif
  end

  logic [NUM_STAGE-1:0]     vld_q, vld_d;
  logic [LANES*P_WIDTH-1:0] res_q [NUM_STAGE];
  logic [LANES*P_WIDTH-1:0] res_d [NUM_STAGE];
  logic [LANES-1:0]         ob_q  [NUM_STAGE];
  logic [LANES-1:0]         ob_d  [NUM_STAGE];
  logic [LANES-1:0]         ovf_q, ovf_d;
  logic                     adv;
  logic                     retire;

  assign adv    = !vld_q[NUM_STAGE-1] || out_ready;
  assign retire = vld_q[NUM_STAGE-1] && out_ready;

  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    ob_d  = ob_q;
    if (adv) begin
      vld_d[0] = in_valid;
      res_d[0] = lane_res;
      ob_d[0]  = lane_ovf;
      for (int s = 1; s < NUM_STAGE; s++) begin
        vld_d[s] = vld_q[s-1];
        res_d[s] = res_q[s-1];
        ob_d[s]  = ob_q[s-1];
      end
    end
    // A retiring overflow wins over a simultaneous clear.
    ovf_d = (ovf_clr ? '0 : ovf_q) | (retire ? ob_q[NUM_STAGE-1] : '0);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      vld_q <= '0;
      ovf_q <= '0;
      for (int s = 0; s < NUM_STAGE; s++) begin
        res_q[s] <= '0;
        ob_q[s]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      ob_q  <= ob_d;
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[NUM_STAGE-1];
  assign dout      = res_q[NUM_STAGE-1];
  assign ovf       = ovf_q;
endmodule

// File: doc/lrhls_mul_pipe.md
# lrhls_mul_pipe

Pipelined, multi-lane unsigned-by-signed multiplier for the LRHLS datapath. It generalises the fixed single-cycle 13×18→18 product to configurable operand and result widths, pipeline depth and lane count. It adds a scaling right-shift with a selectable rounding mode, valid/ready backpressure, and sticky per-lane overflow flags. It sits between the residual/coefficient stages and the accumulators of the linear-regression update.

## Interface
- A_WIDTH, 13, width of unsigned operand a (per lane), 1..26
- B_WIDTH, 18, width of signed operand b (per lane), 2..27
- P_WIDTH, 18, width of signed result (per lane), 2..A_WIDTH+B_WIDTH
- SHIFT, 0, arithmetic right shift applied to the full product, 0..A_WIDTH+B_WIDTH-2
- NUM_STAGE, 3, pipeline latency in cycles, 1..6
- LANES, 1, parallel lanes sharing one handshake, 1..16

- ap_clk  in  1  clock, rising edge
- ap_rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- din0  in  LANES*A_WIDTH  unsigned a operands; lane i at [i*A_WIDTH +: A_WIDTH]
- din1  in  LANES*B_WIDTH  signed b operands; lane i at [i*B_WIDTH +: B_WIDTH]
- rnd_mode  in  1  0 = truncate (floor), 1 = round half up; sampled with the beat
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- dout  out  LANES*P_WIDTH  signed results, same lane packing
- ovf  out  LANES  sticky per-lane overflow flag
- ovf_clr  in  1  synchronous clear of all ovf bits

## Operation
- Full product per lane: $signed({1'b0,a}) * $signed(b), held exactly in A_WIDTH+B_WIDTH+1 bits. No intermediate truncation.
- Scaling:
  - rnd_mode=0 or SHIFT=0: q = prod >>> SHIFT.
  - rnd_mode=1 and SHIFT>0: q = (prod + 2^(SHIFT-1)) >>> SHIFT.
- Narrowing to P_WIDTH: wrap takes the low P_WIDTH bits of q; saturation is covered under Configuration.
- Overflow condition: q is outside [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1]. The overflow sets the lane's ovf bit when the beat retires at the output (out_valid && out_ready). The bit holds until ovf_clr.
- ovf_clr and a retiring overflow in the same cycle: set wins.
- rnd_mode travels down the pipeline with its beat. Changing rnd_mode between beats never affects beats already accepted.
- Pipeline control:
  - NUM_STAGE register stages, each carrying a valid bit.
  - Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv, combinational.
  - On adv every stage shifts by one position. Empty stages shift as bubbles. No compaction.
- Lanes are independent arithmetically and share valid, ready and rnd_mode.

## Timing
- Latency is exactly NUM_STAGE cycles from acceptance to out_valid, when out_ready is held high.
- Throughput is one beat per cycle while out_ready=1.
- While out_valid=1 and out_ready=0:
  - all stages hold;
  - dout and out_valid stay stable;
  - in_ready=0.
- Reset values: out_valid=0, dout=0, ovf=0, all stage valid bits 0. in_ready=1 after reset.
- Assertion of ap_rst mid-stream discards all in-flight beats immediately. Nothing is emitted for them after release.
- dout is registered. in_ready is the only combinational output path (from out_ready).

## Configuration
- LRHLS_MUL_SAT_EN defined:
  - out-of-range q clamps to 2^(P_WIDTH-1)-1 when positive;
  - out-of-range q clamps to -2^(P_WIDTH-1) when negative.
- LRHLS_MUL_SAT_EN undefined: wrap (low P_WIDTH bits), which matches legacy multiplier results bit-for-bit when SHIFT=0.
- ovf reports out-of-range results in both builds.

## Test plan
- Defaults, wrap build. Send a=8191, b=-1. Expect dout=18'h3E001 (-8191) after exactly 3 cycles, ovf=0.
- Defaults, wrap build. Send a=8191, b=131071 (product 1073602561). Expect dout=18'h1E001 and ovf[0]=1 latched; ovf_clr then returns ovf to 0.
- Same stimulus, LRHLS_MUL_SAT_EN build. Expect dout=18'h1FFFF and ovf[0]=1. With a=8191, b=-131072, expect dout=18'h20000.
- SHIFT=4, a=5, b=5 (product 25). Expect dout=1 with rnd_mode=0 and dout=2 with rnd_mode=1. Send a=3, b=-3 under both modes; expect -1 (18'h3FFFF) in both.
- LANES=4, NUM_STAGE=4. Stream 16 back-to-back beats while out_ready is held low for 5 cycles mid-stream. Expect all 16 results in order, none lost or duplicated, and dout stable during the stall.
- Assert ap_rst with 3 beats in flight. Expect out_valid=0, dout=0 and ovf=0 immediately. After release, the next accepted beat emits after NUM_STAGE cycles and no stale beat appears.
